// File: rtl/conv_mem_responder.sv
// Memory-side responder for the convolution controller: image ROM, five layer
// result banks, ready/busy start handshake and protocol-violation tracking.
module conv_mem_responder #(
    parameter int DW   = 20,
    parameter int AW   = 12,
    parameter int L0_N = 4096,
    parameter int L1_N = 1024,
    parameter int L2_N = 2048
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_img_we,
    input  logic [AW-1:0] i_img_waddr,
    input  logic [DW-1:0] i_img_wdata,
    output logic          o_ready,
    input  logic          i_busy,
    input  logic [AW-1:0] i_iaddr,
    output logic [DW-1:0] o_idata,
    input  logic          i_crd,
    input  logic [AW-1:0] i_caddr_rd,
    output logic [DW-1:0] o_cdata_rd,
    input  logic          i_cwr,
    input  logic [AW-1:0] i_caddr_wr,
    input  logic [DW-1:0] i_cdata_wr,
    input  logic [2:0]    i_csel,
    output logic          o_done,
    output logic          o_proto_err,
    output logic [12:0]   o_wr_count
);

    localparam int L0_AW = $clog2(L0_N);
    localparam int L1_AW = $clog2(L1_N);
    localparam int L2_AW = $clog2(L2_N);

    typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_DONE} state_t;

    state_t        r_state;
    logic          r_ready;
    logic          r_done;
    logic          r_proto_err;
    logic [12:0]   r_wr_count;
    logic [DW-1:0] r_idata;
    logic [DW-1:0] r_cdata_rd;
    logic          r_busy_q;

    logic [DW-1:0] r_rom  [L0_N];
    logic [DW-1:0] r_l0m0 [L0_N];
    logic [DW-1:0] r_l0m1 [L0_N];
    logic [DW-1:0] r_l1m0 [L1_N];
    logic [DW-1:0] r_l1m1 [L1_N];
    logic [DW-1:0] r_l2   [L2_N];

    logic          w_run;
    logic          w_sel_ok;
    logic          w_rd_range;
    logic          w_wr_range;
    logic          w_wr_ok;
    logic          w_rd_act;
    logic          w_clr;
    logic          w_err;
    logic [DW-1:0] w_rd_data;

    function automatic logic in_range(input logic [2:0] sel, input logic [AW-1:0] addr);
        case (sel)
            3'b001, 3'b010: in_range = int'(addr) < L0_N;
            3'b011, 3'b100: in_range = int'(addr) < L1_N;
            3'b101:         in_range = int'(addr) < L2_N;
            default:        in_range = 1'b0;
        endcase
    endfunction

    always_comb begin
        w_run      = (r_state == S_RUN);
        w_sel_ok   = (i_csel >= 3'b001) && (i_csel <= 3'b101);
        w_rd_range = in_range(i_csel, i_caddr_rd);
        w_wr_range = in_range(i_csel, i_caddr_wr);
        w_wr_ok    = w_run && i_cwr && w_wr_range;
        // a collision skips the read; an out-of-range read still returns 0
        w_rd_act   = w_run && i_crd && !i_cwr && w_sel_ok;
        w_clr      = (r_state == S_IDLE) && i_start;
        w_err      = ((i_crd || i_cwr) && !w_sel_ok)
                   || (i_crd && i_cwr)
                   || ((i_crd || i_cwr) && !w_run)
                   || (w_run && i_cwr && w_sel_ok && !w_wr_range)
                   || (w_rd_act && !w_rd_range)
                   || ((r_state == S_READY) && r_busy_q && !i_busy);
    end

    always_comb begin
        w_rd_data = '0;
        if (w_rd_range) begin
            case (i_csel)
                3'b001:  w_rd_data = r_l0m0[i_caddr_rd[L0_AW-1:0]];
                3'b010:  w_rd_data = r_l0m1[i_caddr_rd[L0_AW-1:0]];
                3'b011:  w_rd_data = r_l1m0[i_caddr_rd[L1_AW-1:0]];
                3'b100:  w_rd_data = r_l1m1[i_caddr_rd[L1_AW-1:0]];
                3'b101:  w_rd_data = r_l2[i_caddr_rd[L2_AW-1:0]];
                default: w_rd_data = '0;
            endcase
        end
    end

    // arrays carry no reset so their contents survive a mid-run reset
    always_ff @(posedge i_clk) begin
        if ((r_state == S_IDLE) && i_img_we)
            r_rom[i_img_waddr[L0_AW-1:0]] <= i_img_wdata;
        if (w_wr_ok) begin
            case (i_csel)
                3'b001:  r_l0m0[i_caddr_wr[L0_AW-1:0]] <= i_cdata_wr;
                3'b010:  r_l0m1[i_caddr_wr[L0_AW-1:0]] <= i_cdata_wr;
                3'b011:  r_l1m0[i_caddr_wr[L1_AW-1:0]] <= i_cdata_wr;
                3'b100:  r_l1m1[i_caddr_wr[L1_AW-1:0]] <= i_cdata_wr;
                3'b101:  r_l2[i_caddr_wr[L2_AW-1:0]]   <= i_cdata_wr;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_proto_err <= 1'b0;
            r_wr_count  <= '0;
            r_idata     <= '0;
            r_cdata_rd  <= '0;
            r_busy_q    <= 1'b0;
        end else begin
            r_busy_q    <= i_busy;
            r_done      <= 1'b0;
            r_proto_err <= (r_proto_err && !w_clr) || w_err;
            if (w_clr)
                r_wr_count <= '0;
            else if (w_wr_ok && (r_wr_count != 13'h1FFF))
                r_wr_count <= r_wr_count + 13'd1;
            if (w_rd_act)
                r_cdata_rd <= w_rd_data;
            if ((r_state == S_READY) || (r_state == S_RUN))
                r_idata <= r_rom[i_iaddr[L0_AW-1:0]];
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state <= S_READY;
                    r_ready <= 1'b1;
                end
                S_READY: if (i_busy) begin
                    r_state <= S_RUN;
                    r_ready <= 1'b0;
                end
                S_RUN: if (!i_busy) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_done      = r_done;
    assign o_proto_err = r_proto_err;
    assign o_wr_count  = r_wr_count;
    assign o_idata     = r_idata;
    assign o_cdata_rd  = r_cdata_rd;

endmodule
